// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS sequencing FSM with retire counter; MC_MEM_WAIT_EN stalls MEM on mem_ready
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        ir_we,
  output logic        grf_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        dm_we,
  output logic [2:0]  alu_op,
  output logic        alu_src,
  output logic        ext_sign,
  output logic        illegal,
  output logic [31:0] instr_cnt
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t st, nxt;
  logic r_type, addu, subu, jr, nop, ori, lui, lw, sw, beq, jal, legal, mem_done, retire;
  assign r_type = opcode == 6'h00;
  assign addu   = r_type && func == 6'h21;
  assign subu   = r_type && func == 6'h23;
  assign jr     = r_type && func == 6'h08;
  assign nop    = r_type && func == 6'h00;
  assign ori    = opcode == 6'h0d;
  assign lui    = opcode == 6'h0f;
  assign lw     = opcode == 6'h23;
  assign sw     = opcode == 6'h2b;
  assign beq    = opcode == 6'h04;
  assign jal    = opcode == 6'h03;
  assign legal  = addu | subu | jr | nop | ori | lui | lw | sw | beq | jal;
`ifdef MC_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done = 1'b1;
`endif
  assign state    = st;
  assign alu_op   = (subu | beq) ? 3'b001 : ori ? 3'b010 : 3'b000;
  assign alu_src  = ori | lw | sw;
  assign ext_sign = lw | sw | beq;
  assign reg_dst  = jal ? 2'b10 : r_type ? 2'b00 : 2'b01;
  assign wd_sel   = lw ? 2'b01 : lui ? 2'b10 : jal ? 2'b11 : 2'b00;
  assign pc_sel   = st == FETCH ? 2'b00 : jal ? 2'b10 : jr ? 2'b11 : beq ? 2'b01 : 2'b00;
  assign pc_we    = !reset && (st == FETCH || (st == DECODE && (jal | jr)) || (st == EXE && beq && zero));
  assign ir_we    = !reset && st == FETCH;
  assign grf_we   = !reset && ((st == DECODE && jal) || st == WB);
  assign dm_we    = !reset && st == MEM && sw && mem_done;
  assign illegal  = !reset && st == DECODE && !legal;
  assign retire   = (st == DECODE && (jal | jr | nop)) || (st == EXE && beq) ||
                    (st == MEM && sw && mem_done) || st == WB;
  always_comb begin
    nxt = st == FETCH  ? DECODE :
          st == DECODE ? ((jal | jr | nop | !legal) ? FETCH : EXE) :
          st == EXE    ? (beq ? FETCH : (lw | sw) ? MEM : WB) :
          st == MEM    ? (!mem_done ? MEM : lw ? WB : FETCH) : FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= FETCH;
      instr_cnt <= '0;
    end else begin
      st <= nxt;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl; per-cycle expectations queued at drive time, checked at negedge
module tb_mc_ctrl;
  logic        clk = 0, reset = 1, zero = 0, mem_ready = 1;
  logic [5:0]  opcode = 0, func = 0;
  logic [2:0]  state, alu_op;
  logic [1:0]  pc_sel, reg_dst, wd_sel;
  logic        pc_we, ir_we, grf_we, dm_we, alu_src, ext_sign, illegal;
  logic [31:0] instr_cnt, cnt_exp = 0;
  int          errs = 0, checks = 0;
  typedef struct {
    logic [2:0]  st;
    logic [4:0]  en;
    logic [1:0]  ps;
    logic [31:0] cnt;
    logic [8:0]  dc;
  } exp_t;
  exp_t q[$];
  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .grf_we(grf_we),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .dm_we(dm_we), .alu_op(alu_op), .alu_src(alu_src),
    .ext_sign(ext_sign), .illegal(illegal), .instr_cnt(instr_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [8:0] dec(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] a;
    logic s, e;
    logic [1:0] rd, wd;
    a = 3'b000; s = 0; e = 0; rd = 2'b01; wd = 2'b00;
    case (op)
      6'h00: begin rd = 2'b00; if (fn == 6'h23) a = 3'b001; end
      6'h0d: begin a = 3'b010; s = 1; end
      6'h0f: wd = 2'b10;
      6'h23: begin s = 1; e = 1; wd = 2'b01; end
      6'h2b: begin s = 1; e = 1; end
      6'h04: begin a = 3'b001; e = 1; end
      6'h03: begin rd = 2'b10; wd = 2'b11; end
      default: ;
    endcase
    return {a, s, e, rd, wd};
  endfunction
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", {29'd0, state}, {29'd0, e.st});
      chk("enables", {27'd0, pc_we, ir_we, grf_we, dm_we, illegal}, {27'd0, e.en});
      if (e.en[4]) chk("pc_sel", {30'd0, pc_sel}, {30'd0, e.ps});
      chk("decode", {23'd0, alu_op, alu_src, ext_sign, reg_dst, wd_sel}, {23'd0, e.dc});
      chk("instr_cnt", instr_cnt, e.cnt);
    end
  end
  task automatic cyc(input logic r, input logic mr, input logic [2:0] st, input logic [4:0] en, input logic [1:0] ps);
    reset = r;
    mem_ready = mr;
    q.push_back('{st, en, ps, cnt_exp, dec(opcode, func)});
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int waits);
    logic r, i_jal, i_jr, i_nop, i_beq, i_lw, i_sw, ok;
    opcode = op; func = fn; zero = z;
    r = op == 0;
    i_jal = op == 6'h03; i_jr = r && fn == 6'h08; i_nop = r && fn == 6'h00;
    i_beq = op == 6'h04; i_lw = op == 6'h23; i_sw = op == 6'h2b;
    ok = r ? (fn == 6'h21 || fn == 6'h23 || fn == 6'h08 || fn == 6'h00) :
         (op == 6'h0d || op == 6'h0f || i_lw || i_sw || i_beq || i_jal);
    cyc(0, 1, 3'd0, 5'b11000, 2'b00);
    if (i_jal) begin cyc(0, 1, 3'd1, 5'b10100, 2'b10); cnt_exp++; end
    else if (i_jr) begin cyc(0, 1, 3'd1, 5'b10000, 2'b11); cnt_exp++; end
    else if (i_nop) begin cyc(0, 1, 3'd1, 5'b00000, 2'b00); cnt_exp++; end
    else if (!ok) cyc(0, 1, 3'd1, 5'b00001, 2'b00);
    else begin
      cyc(0, 1, 3'd1, 5'b00000, 2'b00);
      if (i_beq) begin cyc(0, 1, 3'd2, {z, 4'b0000}, 2'b01); cnt_exp++; end
      else if (i_lw || i_sw) begin
        cyc(0, 1, 3'd2, 5'b00000, 2'b00);
`ifdef MC_MEM_WAIT_EN
        for (int k = 0; k < waits; k++) cyc(0, 0, 3'd3, 5'b00000, 2'b00);
        if (i_sw) begin cyc(0, 1, 3'd3, 5'b00010, 2'b00); cnt_exp++; end
        else cyc(0, 1, 3'd3, 5'b00000, 2'b00);
`else
        if (i_sw) begin cyc(0, waits == 0, 3'd3, 5'b00010, 2'b00); cnt_exp++; end
        else cyc(0, waits == 0, 3'd3, 5'b00000, 2'b00);
`endif
        if (i_lw) begin cyc(0, 1, 3'd4, 5'b00100, 2'b00); cnt_exp++; end
      end else begin
        cyc(0, 1, 3'd2, 5'b00000, 2'b00);
        cyc(0, 1, 3'd4, 5'b00100, 2'b00);
        cnt_exp++;
      end
    end
  endtask
  initial begin
    reset = 1;
    @(posedge clk);
    #1;
    cnt_exp = 0;
    cyc(1, 1, 3'd0, 5'b00000, 2'b00);
    run(6'h00, 6'h21, 0, 0);
    run(6'h00, 6'h23, 1, 0);
    run(6'h0d, 6'h15, 0, 0);
    run(6'h0f, 6'h00, 0, 0);
    run(6'h04, 6'h00, 1, 0);
    run(6'h04, 6'h00, 0, 0);
    run(6'h03, 6'h2a, 0, 0);
    run(6'h00, 6'h08, 0, 0);
    run(6'h00, 6'h00, 0, 0);
    run(6'h23, 6'h00, 0, 3);
    run(6'h2b, 6'h00, 0, 2);
    run(6'h23, 6'h07, 0, 0);
    run(6'h3f, 6'h00, 0, 0);
    run(6'h00, 6'h3f, 0, 0);
    opcode = 6'h00; func = 6'h21;
    cyc(0, 1, 3'd0, 5'b11000, 2'b00);
    cyc(0, 1, 3'd1, 5'b00000, 2'b00);
    cyc(1, 1, 3'd2, 5'b00000, 2'b00);
    cnt_exp = 0;
    cyc(1, 1, 3'd0, 5'b00000, 2'b00);
    run(6'h00, 6'h21, 0, 0);
    opcode = 6'h2b; func = 6'h00;
    cyc(0, 1, 3'd0, 5'b11000, 2'b00);
    cyc(0, 1, 3'd1, 5'b00000, 2'b00);
    cyc(0, 1, 3'd2, 5'b00000, 2'b00);
    cyc(1, 1, 3'd3, 5'b00000, 2'b00);
    cnt_exp = 0;
    run(6'h04, 6'h00, 1, 0);
    run(6'h03, 6'h00, 0, 0);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the MIPS datapath: a Moore-style FSM that steps each instruction through FETCH/DECODE/EXE/MEM/WB and drives the write enables and mux selects of the shared IFU, GRF, ALU, DM and EXT. It replaces the single-cycle `Controller` once the datapath gets IR/ALU-out/DM-data holding registers, so one ALU and one memory port serve all phases. It also keeps a retired-instruction counter and flags undecodable opcodes.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26], from the datapath instruction register.
- `func` in 6: IR[5:0].
- `zero` in 1: ALU equality flag (A==B), valid in EXE.
- `mem_ready` in 1: DM handshake, used only with `MC_MEM_WAIT_EN`.
- `state` out 3: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- `pc_we` out 1: PC write enable.
- `pc_sel` out 2: 00 PC+4, 01 branch target, 10 jump {PC[31:28],imm26,00}, 11 GRF[rs].
- `ir_we` out 1: IR write enable.
- `grf_we` out 1: GRF write enable.
- `reg_dst` out 2: 00 rd, 01 rt, 10 $31.
- `wd_sel` out 2: 00 ALU-out reg, 01 DM-data reg, 10 {imm16,16'b0}, 11 PC+4.
- `dm_we` out 1: DM write enable.
- `alu_op` out 3: 000 add, 001 sub, 010 or.
- `alu_src` out 1: 0 GRF RD2, 1 imm32.
- `ext_sign` out 1: 1 sign-extend, 0 zero-extend.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `instr_cnt` out 32: retired-instruction count.

## Operation
- Decode classes: addu (R, func 100001), subu (R, 100011), jr (R, 001000), nop (R, func 000000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, jal 000011. Any other opcode, or any other R func, is illegal.
- `alu_op`, `alu_src`, `ext_sign`, `reg_dst` and `wd_sel` are pure functions of `opcode`/`func`, valid in every state.
  - addu, lw, sw: add. subu, beq: sub. ori: or.
  - `alu_src`=1 for ori, lw, sw.
  - `ext_sign`=1 for lw, sw, beq.
  - `reg_dst`: rd for R, rt for I, $31 for jal.
  - `wd_sel`: 00 for addu, subu, ori; 01 for lw; 10 for lui; 11 for jal.
- Enables (`pc_we`, `ir_we`, `grf_we`, `dm_we`) are zero except as listed per state.
- FETCH: `ir_we`=1, `pc_we`=1, `pc_sel`=00 -> DECODE.
- DECODE:
  - jal: `grf_we`=1, `pc_we`=1, `pc_sel`=10, retire -> FETCH.
  - jr: `pc_we`=1, `pc_sel`=11, retire -> FETCH.
  - nop: retire -> FETCH.
  - illegal: `illegal`=1, no retire -> FETCH.
  - else -> EXE.
- EXE:
  - beq: `pc_we`=`zero`, `pc_sel`=01, retire -> FETCH.
  - lw, sw -> MEM.
  - others -> WB.
- MEM:
  - sw: `dm_we`=1, retire -> FETCH.
  - lw -> WB.
- WB: `grf_we`=1, retire -> FETCH.
- Retire: `instr_cnt` increments by 1 on that clock edge and wraps 0xFFFFFFFF -> 0. Illegal instructions never count.
- CPI: jal/jr/nop 2, beq 3, addu/subu/ori/lui/sw 4, lw 5 (no-wait build).

## Timing
- `state` and `instr_cnt` are registered; all other outputs are combinational from `state` + `opcode`/`func` + `zero` (+ `mem_ready`).
- While `reset`=1: `pc_we`, `ir_we`, `grf_we`, `dm_we` and `illegal` are forced to 0.
- First clock edge with `reset`=1: `state`=FETCH, `instr_cnt`=0.
- Reset asserted in any state (including a MEM wait) aborts the instruction on that edge. No partial write is committed and no retire is counted.
- First fetch occurs in the first cycle after `reset` deasserts.
- `opcode`/`func` must hold stable from DECODE through retire; IR loads only in FETCH.

## Configuration
- `MC_MEM_WAIT_EN` defined:
  - MEM holds until `mem_ready`=1.
  - sw: `dm_we` is asserted only in the cycle where `mem_ready`=1, which is the exit cycle.
  - lw: advances to WB in the `mem_ready`=1 cycle.
  - `mem_ready` is ignored in all other states.
- `MC_MEM_WAIT_EN` undefined: `mem_ready` is unused and MEM always lasts exactly one cycle.

## Test plan
- Reset: hold `reset` 2 cycles mid-stream -> `state`=0, `instr_cnt`=0, all enables 0 during reset; `ir_we`=`pc_we`=1 in the first post-reset cycle.
- addu (op 0, func 0x21) -> states 0,1,2,4; `grf_we`=1 only in WB with `reg_dst`=00, `wd_sel`=00; `instr_cnt` +1 after 4 cycles.
- beq with `zero`=1, then with `zero`=0 -> 3 cycles each; `pc_we`=1 with `pc_sel`=01 in EXE only for the taken case; `instr_cnt` +2 total.
- jal (0x03) -> 2 cycles; DECODE has `grf_we`=1, `reg_dst`=10, `wd_sel`=11, `pc_sel`=10.
- lw under `MC_MEM_WAIT_EN` with `mem_ready` low 3 cycles -> 3 extra MEM cycles, then WB with `wd_sel`=01 (8 cycles total); sw -> single `dm_we` pulse coincident with `mem_ready`.
- Illegal: opcode 0x3F -> `illegal` pulse in DECODE, return to FETCH, `instr_cnt` unchanged; R func 0x3F behaves the same.
